// File: rtl/mac_dot_seq.sv
// Dot-product sequencer built around the signed 8x8 MAC datapath
// (radix-4 Booth partial products, 3:2 carry-save tree, ripple final adder).

module mac_booth_pp (
    input  logic [7:0]        a,
    input  logic [7:0]        b,
    output logic [3:0][15:0]  pp
);

    logic [15:0] a_ext;
    logic [15:0] a_neg;
    logic [8:0]  b_ext;
    logic [2:0]  grp;
    logic [15:0] digit;

    // Each overlapping 3-bit window of b selects one of {0, +-a, +-2a}.
    // Partial products are kept 16 bits wide; wrap is the wanted result.
    always_comb begin
        a_ext = {{8{a[7]}}, a};
        a_neg = ~a_ext + 16'd1;
        b_ext = {b, 1'b0};
        grp   = '0;
        digit = '0;
        pp    = '0;
        for (int i = 0; i < 4; i++) begin
            grp = b_ext[2*i +: 3];
            case (grp)
                3'b001, 3'b010: digit = a_ext;
                3'b011:         digit = {a_ext[14:0], 1'b0};
                3'b100:         digit = {a_neg[14:0], 1'b0};
                3'b101, 3'b110: digit = a_neg;
                default:        digit = '0;
            endcase
            pp[i] = digit << (2 * i);
        end
    end

endmodule

module mac_csa32 #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    logic [W-1:0] maj;

    // Carry is returned already weighted (shifted up one place).
    assign sum   = x ^ y ^ z;
    assign maj   = (x & y) | (x & z) | (y & z);
    assign carry = {maj[W-2:0], 1'b0};

endmodule

module mac_cpa #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] sum
);

    logic [W:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign sum[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

endmodule

module mac_s8x8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [15:0] acc,
    output logic [15:0] result
);

    logic [3:0][15:0] pp;
    logic [15:0]      s1, c1, s2, c2, s3, c3;

    mac_booth_pp u_pp (
        .a  (a),
        .b  (b),
        .pp (pp)
    );

    mac_csa32 #(.W(16)) u_csa1 (.x(pp[0]), .y(pp[1]), .z(pp[2]), .sum(s1), .carry(c1));
    mac_csa32 #(.W(16)) u_csa2 (.x(s1),    .y(c1),    .z(pp[3]), .sum(s2), .carry(c2));
    mac_csa32 #(.W(16)) u_csa3 (.x(s2),    .y(c2),    .z(acc),   .sum(s3), .carry(c3));

    mac_cpa #(.W(16)) u_cpa (
        .x   (s3),
        .y   (c3),
        .sum (result)
    );

endmodule

module mac_dot_seq #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [15:0]      acc_init,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic [LEN_W-1:0] count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [15:0]      mac_out;

    mac_s8x8 u_mac (
        .a      (in_a),
        .b      (in_b),
        .acc    (acc_q),
        .result (mac_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
        end
    end

    // Handshake outputs decode from state only, so in_ready never waits on in_valid.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        busy        = 1'b0;
        in_ready    = 1'b0;
        res_valid   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d       = acc_init;
                    count_d     = '0;
                    remaining_d = len;
                    state_d     = (len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d       = mac_out;
                    count_d     = count_q + LEN_W'(1);
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign res_data = acc_q;
    assign count    = count_q;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq: a table of complete dot products plus
// hand-written backpressure, reset-abort and back-to-back sequences.

module tb_mac_dot_seq;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic [15:0]      acc_init = '0;
    logic             busy;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_a = '0;
    logic [7:0]       in_b = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [15:0]      res_data;
    logic [LEN_W-1:0] count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string           name;
        int              len;
        logic [15:0]     acc_init;
        logic [3:0][7:0] a;
        logic [3:0][7:0] b;
        logic [15:0]     exp_res;
    } vec_t;

    vec_t vecs[8];

    mac_dot_seq #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .acc_init  (acc_init),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want test end");
        $fatal(1, "[TB] simulation hung");
    end

    function automatic vec_t mkv(input string name, input int l, input int init,
                                 input int a0, input int b0, input int a1, input int b1,
                                 input int a2, input int b2, input int a3, input int b3,
                                 input int exp_res);
        vec_t v;
        v.name     = name;
        v.len      = l;
        v.acc_init = init[15:0];
        v.a[0] = a0[7:0]; v.b[0] = b0[7:0];
        v.a[1] = a1[7:0]; v.b[1] = b1[7:0];
        v.a[2] = a2[7:0]; v.b[2] = b2[7:0];
        v.a[3] = a3[7:0]; v.b[3] = b3[7:0];
        v.exp_res = exp_res[15:0];
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Runs one whole operation starting from IDLE at a falling edge, pairs streamed back to back.
    task automatic applyStimulus(input vec_t v, input logic hs_start);
        int beats;
        int ready_cycles;
        int guard;
        start    = 1'b1;
        len      = v.len[LEN_W-1:0];
        acc_init = v.acc_init;
        @(negedge clk);
        start    = 1'b0;
        len      = 8'hAA;
        acc_init = 16'hDEAD;
        beats = 0;
        ready_cycles = 0;
        guard = 0;
        while (beats < v.len && guard < 64) begin
            in_valid = 1'b1;
            in_a     = v.a[beats];
            in_b     = v.b[beats];
            if (in_ready) begin
                ready_cycles++;
                beats++;
            end
            guard++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_a     = 8'h5A;
        in_b     = 8'hA5;
        checkOutput({v.name, " ready_cycles"}, ready_cycles, v.len);
        checkOutput({v.name, " res_valid"}, res_valid, 1);
        checkOutput({v.name, " in_ready_done"}, in_ready, 0);
        checkOutput({v.name, " busy_done"}, busy, 1);
        checkOutput({v.name, " res_data"}, res_data, v.exp_res);
        checkOutput({v.name, " count"}, count, v.len);
        res_ready = 1'b1;
        if (hs_start) begin
            start    = 1'b1;
            len      = 8'd1;
            acc_init = 16'h7777;
        end
        @(negedge clk);
        res_ready = 1'b0;
        start     = 1'b0;
        checkOutput({v.name, " res_valid_after"}, res_valid, 0);
        checkOutput({v.name, " busy_after"}, busy, 0);
    endtask

    initial begin
        vecs[0] = mkv("basic",   3, 16'h0000,    2, 3,   -4, 5,     7, -1,   0, 0,  16'hFFEB);
        vecs[1] = mkv("wrap",    2, 16'h0000, -128, -128, -128, -128, 0, 0,   0, 0,  16'h8000);
        vecs[2] = mkv("zerolen", 0, 16'h1234,    9, 9,    9, 9,     9, 9,    9, 9,  16'h1234);
        vecs[3] = mkv("mixed4",  4, 16'h7FF0,  127, 127, -128, 127, 1, -1,  -3, -3, 16'h7F79);
        vecs[4] = mkv("negwrap", 1, 16'h8000,   -1, 1,    0, 0,     0, 0,    0, 0,  16'h7FFF);
        vecs[5] = mkv("bias",    1, 16'hFFFB,   -1, 5,    0, 0,     0, 0,    0, 0,  16'hFFF6);
        vecs[6] = mkv("tripneg", 3, 16'h0000, -128, 127, -128, 127, -128, 127, 0, 0, 16'h4180);
        vecs[7] = mkv("booth",   2, 16'h0100,    0, -77,  85, -86,  0, 0,    0, 0,  16'hE472);

        repeat (2) @(negedge clk);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset in_ready", in_ready, 0);
        checkOutput("reset res_valid", res_valid, 0);
        checkOutput("reset res_data", res_data, 0);
        checkOutput("reset count", count, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], 1'b0);
        end

        // Backpressure on both sides, with start pulses that must be ignored.
        start = 1'b1; len = 8'd2; acc_init = 16'h0010;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1;
        checkOutput("bp first ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; in_a = 8'h55; in_b = 8'h66;
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp gap acc", res_data, 16'h0011);
            checkOutput("bp gap count", count, 1);
            checkOutput("bp gap res_valid", res_valid, 0);
            start = (i == 1); len = 8'd5; acc_init = 16'h0000;
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b1; in_a = 8'd2; in_b = 8'd2;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp hold res_valid", res_valid, 1);
            checkOutput("bp hold res_data", res_data, 16'h0015);
            checkOutput("bp hold count", count, 2);
            start = (i == 2); len = 8'd3; acc_init = 16'h4444;
            @(negedge clk);
            start = 1'b0;
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checkOutput("bp busy after hs", busy, 0);
        checkOutput("bp res_valid after hs", res_valid, 0);
        @(negedge clk);
        checkOutput("bp still idle", busy, 0);

        // Reset two beats into a four-beat run.
        start = 1'b1; len = 8'd4; acc_init = 16'h0100;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst pre acc", res_data, 16'h0102);
        checkOutput("rst pre count", count, 2);
        rst = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("rst busy", busy, 0);
        checkOutput("rst in_ready", in_ready, 0);
        checkOutput("rst res_valid", res_valid, 0);
        checkOutput("rst res_data", res_data, 0);
        checkOutput("rst count", count, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst no result", res_valid, 0);
        applyStimulus(mkv("after_rst", 1, 16'h0000, 3, 3, 0, 0, 0, 0, 0, 0, 16'h0009), 1'b0);

        // Start in the handshake cycle is dropped; the next IDLE cycle's start runs.
        applyStimulus(mkv("b2b_first", 1, 16'h0000, 4, 4, 0, 0, 0, 0, 0, 0, 16'h0010), 1'b1);
        applyStimulus(mkv("b2b_second", 1, 16'hFFFB, -1, 5, 0, 0, 0, 0, 0, 0, 16'hFFF6), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
